// File: rtl/harness_exit_monitor.sv
// harness_exit_monitor: collects tohost-style exit reports from NUM_SRC sources
// and resolves them into a sticky harness-level pass/fail verdict.
// A round-robin arbiter accepts at most one report per cycle.
// Exit code 0 from every source gives pass.
// A nonzero exit code or a watchdog expiry gives fail.
// Once a verdict is reached, every source is drained so that none can hang.
module harness_exit_monitor #(
  parameter int NUM_SRC  = 2,
  parameter int SRC_W    = 4,
  parameter int WATCHDOG = 1000000,
  parameter int CNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   io_req_valid,
  input  logic [32*NUM_SRC-1:0] io_req_bits,
  output logic [NUM_SRC-1:0]   io_req_ready,
  output logic                 io_success,
  output logic                 io_failure,
  output logic                 io_fail_timeout,
  output logic [30:0]          io_fail_code,
  output logic [SRC_W-1:0]     io_fail_src,
  output logic [NUM_SRC-1:0]   io_done_mask
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [NUM_SRC-1:0] ALL_DONE = {NUM_SRC{1'b1}};
  localparam logic [SRC_W-1:0]   LAST_SRC = SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0]   WD_LAST  = CNT_W'(WATCHDOG - 1);

  state_t              state_r, state_nxt_s;
  logic [NUM_SRC-1:0]  done_r, done_nxt_s;
  logic [30:0]         code_r, code_nxt_s;
  logic [SRC_W-1:0]    src_r, src_nxt_s;
  logic                tmo_r, tmo_nxt_s;
  logic [SRC_W-1:0]    ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                success_r, failure_r;

  logic                hi_found_s, lo_found_s;
  logic [SRC_W-1:0]    hi_idx_s, lo_idx_s, grant_s;
  logic [NUM_SRC-1:0]  grant_oh_s;
  logic [31:0]         word_s;
  logic                accept_s;

  // Round-robin search: the lowest valid index at/after the pointer, else the lowest overall (wrap).
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (io_req_valid[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = SRC_W'(i);
        if (SRC_W'(i) >= ptr_r) begin
          hi_found_s = 1'b1;
          hi_idx_s   = SRC_W'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    if (hi_found_s) begin
      grant_s = hi_idx_s;
    end else begin
      grant_s = lo_idx_s;
    end
  end

  // One-hot grant, the selected report word, and ready: the grant in RUN, all ones once terminal.
  always_comb begin
    grant_oh_s = '0;
    word_s     = 32'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (lo_found_s && (grant_s == SRC_W'(i))) begin
        grant_oh_s[i] = 1'b1;
        word_s        = io_req_bits[32*i +: 32];
      end else begin
        grant_oh_s[i] = 1'b0;
      end
    end
    if (state_r == ST_RUN) begin
      io_req_ready = grant_oh_s;
      accept_s     = lo_found_s;
    end else begin
      io_req_ready = ALL_DONE;
      accept_s     = 1'b0;
    end
  end

  // Next-state logic: decodes the accepted report, runs the watchdog and handles pointer advance.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = done_r;
    code_nxt_s  = code_r;
    src_nxt_s   = src_r;
    tmo_nxt_s   = tmo_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s) begin
          cnt_nxt_s = '0;
          if (grant_s == LAST_SRC) begin
            ptr_nxt_s = '0;
          end else begin
            ptr_nxt_s = grant_s + SRC_W'(1);
          end
          if (word_s[0]) begin
            if (word_s[31:1] == 31'd0) begin
              // Exit code 0. A repeat from a source that is already done changes nothing.
              done_nxt_s = done_r | grant_oh_s;
              if ((done_r | grant_oh_s) == ALL_DONE) begin
                state_nxt_s = ST_PASS;
              end else begin
                state_nxt_s = ST_RUN;
              end
            end else begin
              state_nxt_s = ST_FAIL;
              code_nxt_s  = word_s[31:1];
              src_nxt_s   = grant_s;
              tmo_nxt_s   = 1'b0;
            end
          end else begin
            // Non-exit word: it only keeps the watchdog alive.
            state_nxt_s = ST_RUN;
          end
        end else if (WATCHDOG > 0) begin
          if (cnt_r == WD_LAST) begin
            state_nxt_s = ST_FAIL;
            code_nxt_s  = 31'd0;
            src_nxt_s   = '0;
            tmo_nxt_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_PASS: begin
        state_nxt_s = ST_PASS;
      end
      ST_FAIL: begin
        state_nxt_s = ST_FAIL;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State and verdict registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_RUN;
      done_r    <= '0;
      code_r    <= 31'd0;
      src_r     <= '0;
      tmo_r     <= 1'b0;
      ptr_r     <= '0;
      cnt_r     <= '0;
      success_r <= 1'b0;
      failure_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      done_r    <= done_nxt_s;
      code_r    <= code_nxt_s;
      src_r     <= src_nxt_s;
      tmo_r     <= tmo_nxt_s;
      ptr_r     <= ptr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      success_r <= (state_nxt_s == ST_PASS);
      failure_r <= (state_nxt_s == ST_FAIL);
    end
  end

  assign io_success      = success_r;
  assign io_failure      = failure_r;
  assign io_fail_timeout = tmo_r;
  assign io_fail_code    = code_r;
  assign io_fail_src     = src_r;
  assign io_done_mask    = done_r;

endmodule

// File: tb/tb_harness_exit_monitor.sv
// Directed, table-driven bench for harness_exit_monitor (NUM_SRC=2, WATCHDOG=50).
module tb_harness_exit_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  io_req_valid;
  logic [63:0] io_req_bits;
  logic [1:0]  io_req_ready;
  logic        io_success, io_failure, io_fail_timeout;
  logic [30:0] io_fail_code;
  logic [3:0]  io_fail_src;
  logic [1:0]  io_done_mask;

  int errors = 0;
  int checks = 0;

  harness_exit_monitor #(
    .NUM_SRC(2), .SRC_W(4), .WATCHDOG(50), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_bits(io_req_bits),
    .io_req_ready(io_req_ready),
    .io_success(io_success), .io_failure(io_failure),
    .io_fail_timeout(io_fail_timeout), .io_fail_code(io_fail_code),
    .io_fail_src(io_fail_src), .io_done_mask(io_done_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [1:0]  rdy;
    logic        succ;
    logic        fail;
    logic        tmo;
    logic [30:0] code;
    logic [3:0]  src;
    logic [1:0]  mask;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] v, input logic [31:0] b0, input logic [31:0] b1,
                     input logic [1:0] rdy, input logic s, input logic f, input logic t,
                     input logic [30:0] c, input logic [3:0] src, input logic [1:0] m);
    vec_t x;
    x.rst = r; x.valid = v; x.b0 = b0; x.b1 = b1; x.rdy = rdy; x.succ = s; x.fail = f;
    x.tmo = t; x.code = c; x.src = src; x.mask = m;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [31:0] b0, input logic [31:0] b1);
    reset = r;
    io_req_valid = v;
    io_req_bits = {b1, b0};
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic s, input logic f, input logic t,
                            input logic [30:0] c, input logic [3:0] src, input logic [1:0] m);
    check("success", idx, 64'(io_success), 64'(s));
    check("failure", idx, 64'(io_failure), 64'(f));
    check("timeout", idx, 64'(io_fail_timeout), 64'(t));
    check("fail_code", idx, 64'(io_fail_code), 64'(c));
    check("fail_src", idx, 64'(io_fail_src), 64'(src));
    check("done_mask", idx, 64'(io_done_mask), 64'(m));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //   rst  valid b0            b1            rdy   s     f     t     code           src   mask
    add(1'b1, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b01, 32'h1,        32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b01);
    add(1'b0, 2'b01, 32'h1,        32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b01);
    add(1'b0, 2'b01, 32'h1,        32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b01);
    add(1'b0, 2'b10, 32'h0,        32'h1,        2'b10, 1'b1, 1'b0, 1'b0, 31'h0,        4'd0, 2'b11);
    add(1'b0, 2'b01, 32'hF,        32'h0,        2'b11, 1'b1, 1'b0, 1'b0, 31'h0,        4'd0, 2'b11);
    add(1'b0, 2'b00, 32'h0,        32'h0,        2'b11, 1'b1, 1'b0, 1'b0, 31'h0,        4'd0, 2'b11);
    add(1'b1, 2'b00, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b11, 32'h1,        32'h7,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b01);
    add(1'b0, 2'b11, 32'h1,        32'h7,        2'b10, 1'b0, 1'b1, 1'b0, 31'h3,        4'd1, 2'b01);
    add(1'b0, 2'b11, 32'h1,        32'h1,        2'b11, 1'b0, 1'b1, 1'b0, 31'h3,        4'd1, 2'b01);
    add(1'b1, 2'b00, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b11, 32'h1,        32'h1,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b01);
    add(1'b0, 2'b11, 32'h1,        32'h1,        2'b10, 1'b1, 1'b0, 1'b0, 31'h0,        4'd0, 2'b11);
    add(1'b1, 2'b00, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b10, 32'h0,        32'h2,        2'b10, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b11, 32'h2,        32'h2,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b01, 32'h1,        32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b01);
    add(1'b0, 2'b11, 32'h1,        32'h1,        2'b10, 1'b1, 1'b0, 1'b0, 31'h0,        4'd0, 2'b11);
    add(1'b1, 2'b00, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 1'b0, 31'h0,        4'd0, 2'b00);
    add(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0, 31'h7FFFFFFF, 4'd0, 2'b00);

    drive(1'b1, 2'b00, 32'h0, 32'h0);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].b0, vecs[i].b1);
      #1;
      check("ready", i, 64'(io_req_ready), 64'(vecs[i].rdy));
      tick();
      check_outs(i, vecs[i].succ, vecs[i].fail, vecs[i].tmo, vecs[i].code, vecs[i].src, vecs[i].mask);
    end

    // Watchdog expiry with no traffic: the failure appears on the 50th edge after reset.
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (49) tick();
    check("wd_before_expiry", 100, 64'(io_failure), 64'd0);
    tick();
    check_outs(101, 1'b0, 1'b1, 1'b1, 31'h0, 4'd0, 2'b00);
    check("wd_fail_ready", 101, 64'(io_req_ready), 64'h3);

    // An accept in the expiring cycle wins, then a fresh 50-cycle window applies.
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (49) tick();
    drive(1'b0, 2'b01, 32'h2, 32'h0);
    #1;
    check("wd_rescue_ready", 102, 64'(io_req_ready), 64'h1);
    tick();
    check("wd_rescued", 102, 64'(io_failure), 64'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (49) tick();
    check("wd_second_window", 103, 64'(io_failure), 64'd0);
    tick();
    check_outs(104, 1'b0, 1'b1, 1'b1, 31'h0, 4'd0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
